// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter for the write-through dcache: NumPorts requesters share one read controller.
// Define WT_DCACHE_RD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
package wt_dcache_rd_arb_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned DcacheIndexWidth;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64, DcacheIndexWidth: 32'd12};

  localparam int unsigned IndexW = 12;
  localparam int unsigned TagW   = 20;
  localparam int unsigned DataW  = 64;
  localparam int unsigned UserW  = 8;
  localparam int unsigned IdW    = 4;

  typedef struct packed {
    logic              data_req;
    logic [IndexW-1:0] address_index;
    logic [1:0]        data_size;
    logic [IdW-1:0]    data_id;
    logic              tag_valid;
    logic [TagW-1:0]   address_tag;
    logic              kill_req;
  } dcache_req_t;

  typedef struct packed {
    logic             data_gnt;
    logic             data_rvalid;
    logic [DataW-1:0] data_rdata;
    logic [UserW-1:0] data_ruser;
    logic [IdW-1:0]   data_rid;
  } dcache_rsp_t;

endpackage

module wt_dcache_rd_arb #(
  parameter wt_dcache_rd_arb_pkg::cva6_cfg_t CVA6Cfg = wt_dcache_rd_arb_pkg::cva6_cfg_empty,
  parameter int unsigned NumPorts = 3,
  parameter type dcache_req_t = wt_dcache_rd_arb_pkg::dcache_req_t,
  parameter type dcache_rsp_t = wt_dcache_rd_arb_pkg::dcache_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  dcache_req_t req_ports_i [NumPorts],
  output dcache_rsp_t rsp_ports_o [NumPorts],
  output dcache_req_t ctrl_req_o,
  input  dcache_rsp_t ctrl_rsp_i
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  typedef logic [PortW-1:0] port_t;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state;
  port_t       owner;
  port_t       winner;
  port_t       cand;
  port_t       sel;
  logic        win_valid;
  int unsigned idx;
`ifndef WT_DCACHE_RD_ARB_FIXED_PRIO_EN
  port_t       rr_ptr;
`endif

  // Configuration only sizes the default types; nothing here depends on it.
  logic unused_cfg;
  assign unused_cfg = ^{CVA6Cfg.XLEN, CVA6Cfg.DcacheIndexWidth};

  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
`ifdef WT_DCACHE_RD_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = 32'(rr_ptr) + i;
      if (idx >= NumPorts) begin
        idx = idx - NumPorts;
      end
`endif
      cand = port_t'(idx);
      if (!win_valid && req_ports_i[cand].data_req) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  assign sel = (state == StBusy) ? owner : winner;

  // Tag/kill belong to the granted transaction; a new request is held off while one is open.
  always_comb begin
    ctrl_req_o = req_ports_i[sel];
    if (state == StBusy) begin
      ctrl_req_o.data_req = 1'b0;
    end else begin
      ctrl_req_o.data_req  = win_valid;
      ctrl_req_o.tag_valid = 1'b0;
      ctrl_req_o.kill_req  = 1'b0;
    end
    if (!rst_ni) begin
      ctrl_req_o.data_req  = 1'b0;
      ctrl_req_o.tag_valid = 1'b0;
      ctrl_req_o.kill_req  = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      rsp_ports_o[i] = '0;
      if (rst_ni) begin
        if (state == StIdle && win_valid && winner == port_t'(i)) begin
          rsp_ports_o[i].data_gnt = ctrl_rsp_i.data_gnt;
        end
        if (state == StBusy && owner == port_t'(i)) begin
          rsp_ports_o[i]          = ctrl_rsp_i;
          rsp_ports_o[i].data_gnt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= StIdle;
      owner  <= '0;
`ifndef WT_DCACHE_RD_ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (win_valid && ctrl_rsp_i.data_gnt) begin
            owner <= winner;
            state <= StBusy;
          end
        end
        StBusy: begin
          if (ctrl_rsp_i.data_rvalid) begin
            state <= StIdle;
`ifndef WT_DCACHE_RD_ARB_FIXED_PRIO_EN
            rr_ptr <= (owner == port_t'(NumPorts - 1)) ? '0 : port_t'(owner + 1'b1);
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Scoreboard bench for wt_dcache_rd_arb: expected grant/rvalid events are queued up front and
// popped by a monitor whenever any requester port shows a grant or a response.
module tb_wt_dcache_rd_arb;
  import wt_dcache_rd_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  dcache_req_t req [3];
  dcache_rsp_t rsp [3];
  dcache_req_t ctrl_req;
  dcache_rsp_t ctrl_rsp;

  logic        auto_gnt;
  logic        force_gnt;
  logic        force_rv;
  logic        rv;
  logic [63:0] rdata;
  int          pend;
  int          n_rsp;

  int checks;
  int errors;

  typedef struct {
    bit          is_rv;
    int          port;
    logic [63:0] data;
  } ev_t;
  ev_t q[$];

  wt_dcache_rd_arb #(
    .NumPorts(3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_ports_i(req),
    .rsp_ports_o(rsp),
    .ctrl_req_o (ctrl_req),
    .ctrl_rsp_i (ctrl_rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    ctrl_rsp             = '0;
    ctrl_rsp.data_gnt    = force_gnt | (auto_gnt & ctrl_req.data_req);
    ctrl_rsp.data_rvalid = rv | force_rv;
    ctrl_rsp.data_rdata  = rdata;
    ctrl_rsp.data_rid    = rdata[3:0];
  end

  // Controller model: responds two cycles after each grant with a numbered data word.
  initial begin
    rv    = 1'b0;
    rdata = '0;
    pend  = 0;
    n_rsp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      else if (ctrl_req.data_req && ctrl_rsp.data_gnt) pend = 2;
      @(posedge clk);
      #1;
      rv = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          rv    = 1'b1;
          rdata = 64'hD000 + 64'(n_rsp);
          n_rsp = n_rsp + 1;
        end
      end
    end
  end

  task automatic exp_ev(input bit is_rv, input int port, input int k);
    ev_t e;
    e.is_rv = is_rv;
    e.port  = port;
    e.data  = is_rv ? 64'hD000 + 64'(k) : 64'h0;
    q.push_back(e);
  endtask

  task automatic check_evt(input bit is_rv, input int port, input logic [63:0] data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_evt got rv=%0d port=%0d data=%h, required none", is_rv, port, data);
    end else begin
      e = q.pop_front();
      if (e.is_rv != is_rv || e.port != port || (is_rv && e.data != data)) begin
        errors++;
        $display("FAIL evt got rv=%0d port=%0d data=%h, required rv=%0d port=%0d data=%h",
                 is_rv, port, data, e.is_rv, e.port, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (rsp[i].data_gnt) check_evt(1'b0, i, 64'h0);
        if (rsp[i].data_rvalid) check_evt(1'b1, i, rsp[i].data_rdata);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_gnt"}, 64'(rsp[i].data_gnt), 64'h0);
      chk({tag, "_rvalid"}, 64'(rsp[i].data_rvalid), 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    auto_gnt  = 1'b0;
    force_gnt = 1'b1;
    force_rv  = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = '0;
    req[0].data_req  = 1'b1;
    req[0].tag_valid = 1'b1;
    req[0].kill_req  = 1'b1;

    // Reset: everything quiet even with the controller shouting.
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_ctrl_req", 64'(ctrl_req.data_req), 64'h0);
    chk("rst_ctrl_tag_valid", 64'(ctrl_req.tag_valid), 64'h0);
    chk("rst_ctrl_kill", 64'(ctrl_req.kill_req), 64'h0);
    force_gnt = 1'b0;
    force_rv  = 1'b0;
    req[0]    = '0;
    step();
    rst_n    = 1'b1;
    auto_gnt = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 64'(ctrl_req.data_req), 64'h0);

    // Ports 0 and 2 request continuously.
`ifdef WT_DCACHE_RD_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      exp_ev(1'b0, 0, 0);
      exp_ev(1'b1, 0, k);
    end
`else
    exp_ev(1'b0, 0, 0); exp_ev(1'b1, 0, 0);
    exp_ev(1'b0, 2, 0); exp_ev(1'b1, 2, 1);
    exp_ev(1'b0, 0, 0); exp_ev(1'b1, 0, 2);
    exp_ev(1'b0, 2, 0); exp_ev(1'b1, 2, 3);
`endif
    step();
    req[0].data_req = 1'b1;
    req[2].data_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (q.size() == 0) break;
    end
    req[0].data_req = 1'b0;
    req[2].data_req = 1'b0;
    chk("s1_qempty", 64'(q.size()), 64'h0);
    q.delete();

    // Port 1 granted, then kills its access.
    exp_ev(1'b0, 1, 0);
    exp_ev(1'b1, 1, 4);
    step();
    req[1].data_req      = 1'b1;
    req[1].address_index = 12'h111;
    @(negedge clk);
    chk("s2_ctrl_req", 64'(ctrl_req.data_req), 64'h1);
    chk("s2_ctrl_index", 64'(ctrl_req.address_index), 64'h111);
    step();
    req[1].data_req    = 1'b0;
    req[1].tag_valid   = 1'b1;
    req[1].kill_req    = 1'b1;
    req[1].address_tag = 20'hABCDE;
    @(negedge clk);
    chk("s2_kill", 64'(ctrl_req.kill_req), 64'h1);
    chk("s2_tag_valid", 64'(ctrl_req.tag_valid), 64'h1);
    chk("s2_tag", 64'(ctrl_req.address_tag), 64'hABCDE);
    chk("s2_busy_mask", 64'(ctrl_req.data_req), 64'h0);
    step();
    req[1].tag_valid = 1'b0;
    req[1].kill_req  = 1'b0;
    step();
    chk("s2_qempty", 64'(q.size()), 64'h0);
    q.delete();

    // Wrap-around, busy masking, and stray grant/rvalid handling.
    exp_ev(1'b0, 0, 0); exp_ev(1'b1, 0, 5);
    exp_ev(1'b0, 1, 0); exp_ev(1'b1, 1, 6);
    exp_ev(1'b0, 0, 0); exp_ev(1'b1, 0, 7);
    req[0].data_req      = 1'b1;
    req[0].address_index = 12'h0A0;
    req[1].data_req      = 1'b1;
    req[1].address_index = 12'h1B1;
    @(negedge clk);
    chk("s3_wrap_index", 64'(ctrl_req.address_index), 64'h0A0);
    step();
    req[0].data_req = 1'b0;
    force_gnt       = 1'b1;
    @(negedge clk);
    chk("s3_busy_mask_a", 64'(ctrl_req.data_req), 64'h0);
    step();
    force_gnt = 1'b0;
    @(negedge clk);
    chk("s3_busy_mask_b", 64'(ctrl_req.data_req), 64'h0);
    step();
    @(negedge clk);
    chk("s3_req1_fwd", 64'(ctrl_req.data_req), 64'h1);
    chk("s3_req1_index", 64'(ctrl_req.address_index), 64'h1B1);
    step();
    req[1].data_req = 1'b0;
    req[0].data_req = 1'b1;
    @(negedge clk);
    chk("s3_busy_req0_a", 64'(ctrl_req.data_req), 64'h0);
    step();
    @(negedge clk);
    chk("s3_busy_req0_b", 64'(ctrl_req.data_req), 64'h0);
    step();
    @(negedge clk);
    chk("s3_req0_after", 64'(ctrl_req.data_req), 64'h1);
    chk("s3_req0_index", 64'(ctrl_req.address_index), 64'h0A0);
    step();
    req[0].data_req = 1'b0;
    step();
    step();
    force_rv = 1'b1;
    @(negedge clk);
    chk_quiet("s3_idle_rv");
    step();
    force_rv = 1'b0;
    chk("s3_qempty", 64'(q.size()), 64'h0);
    q.delete();

    // Reset right after a grant to port 2 drops the transaction.
    exp_ev(1'b0, 2, 0);
    exp_ev(1'b0, 0, 0);
    exp_ev(1'b1, 0, 8);
    req[2].data_req = 1'b1;
    step();
    rst_n           = 1'b0;
    force_gnt       = 1'b1;
    force_rv        = 1'b1;
    req[0].data_req = 1'b1;
    @(negedge clk);
    chk_quiet("s4_rst");
    chk("s4_rst_ctrl_req", 64'(ctrl_req.data_req), 64'h0);
    step();
    rst_n     = 1'b1;
    force_gnt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("s4_no_rv", 64'(rsp[i].data_rvalid), 64'h0);
    step();
    force_rv        = 1'b0;
    req[0].data_req = 1'b0;
    req[2].data_req = 1'b0;
    step();
    step();
    chk("s4_qempty", 64'(q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
